// File: rtl/imem_uart_loader.sv
// -----------------------------------------------------------------------------
// imem_uart_loader
//
// Serial program loader for the instruction memory. An 8N1 UART byte stream
// framed as  HEADER, N, then 4*N data bytes  is assembled into little-endian
// 32-bit words and written word by word through the memory write port. While
// a load is in progress the core is held in clear; it is released once the
// last word of a well-formed frame has been written.
//
// Ports
//   clock      system clock, all state changes on the rising edge
//   clear      asynchronous active-low reset
//   rx         UART receive line (idle high, LSB first), asynchronous
//   mem_addr   byte address of the word being written (multiple of 4)
//   mem_din    assembled word, first received byte in [7:0]
//   mem_wren   single-cycle write strobe
//   core_hold  1 = keep the core in clear
//   done       1 = last load completed successfully
//   error      1 = framing or length error, sticky until clear or new HEADER
// -----------------------------------------------------------------------------
module imem_uart_loader #(
    parameter int         CLK_DIV    = 434,
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] HEADER     = 8'h55,
    parameter int         BOOT_HOLD  = 1
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  rx,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    output logic                  mem_wren,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error
);

    localparam logic [15:0] FULL  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF  = 16'(CLK_DIV / 2 - 1);
    localparam int          MAX_N = 2 ** (ADDR_WIDTH - 2);
    // words_left must hold MAX_N itself, hence one bit more than word_idx
    localparam int          WL_W  = ADDR_WIDTH - 1;

    // ------------------------------------------------------------------
    // RX synchroniser; rx_prev gives the previous synchronised sample for
    // falling-edge (start bit) detection.
    // ------------------------------------------------------------------
    logic rx_s1, rx_s2, rx_prev;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   rx_state, rx_state_n;
    logic [15:0] baud_cnt, baud_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [7:0]  shreg, shreg_n;
    logic        byte_valid, frame_err;
    logic [7:0]  rx_byte;

    assign rx_byte = shreg;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            rx_state <= RX_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            rx_state <= rx_state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        baud_n     = baud_cnt + 16'd1;
        bit_n      = bit_cnt;
        shreg_n    = shreg;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                baud_n = '0;
                if (rx_prev && !rx_s2) rx_state_n = RX_START;
            end
            RX_START: begin
                // Mid-start re-check: a line already back high was a glitch
                if (baud_cnt == HALF) begin
                    baud_n     = '0;
                    bit_n      = '0;
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (baud_cnt == FULL) begin
                    baud_n  = '0;
                    shreg_n = {rx_s2, shreg[7:1]};
                    bit_n   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (baud_cnt == FULL) begin
                    baud_n     = '0;
                    byte_valid = rx_s2;
                    frame_err  = !rx_s2;
                    rx_state_n = RX_IDLE;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;

    state_t                state, state_n;
    logic [WL_W-1:0]       words_left;
    logic [ADDR_WIDTH-3:0] word_idx;
    logic [1:0]            byte_cnt;
    logic                  len_ok;

    assign len_ok = (rx_byte != 8'd0) && ({24'd0, rx_byte} <= 32'(MAX_N));

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state      <= S_IDLE;
            words_left <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            mem_addr   <= '0;
            mem_din    <= '0;
        end else begin
            state <= state_n;
            if (state == S_LEN && byte_valid) begin
                words_left <= WL_W'(rx_byte);
                word_idx   <= '0;
                byte_cnt   <= '0;
            end
            if (state == S_DATA && byte_valid) begin
                mem_din[{byte_cnt, 3'b000} +: 8] <= rx_byte;
                byte_cnt <= byte_cnt + 2'd1;
                // Address is latched with the last byte so it stays put
                // through and after the strobe while word_idx advances.
                if (byte_cnt == 2'd3) mem_addr <= {word_idx, 2'b00};
            end
            if (state == S_WRITE) begin
                word_idx   <= word_idx + 1'b1;
                words_left <= words_left - 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (byte_valid && rx_byte == HEADER) state_n = S_LEN;
            end
            S_LEN: begin
                if (byte_valid)     state_n = len_ok ? S_DATA : S_ERR;
                else if (frame_err) state_n = S_ERR;
            end
            S_DATA: begin
                if (frame_err)                            state_n = S_ERR;
                else if (byte_valid && byte_cnt == 2'd3)  state_n = S_WRITE;
            end
            S_WRITE: begin
                state_n = (words_left == WL_W'(1)) ? S_DONE : S_DATA;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // IDLE is only reachable through reset, so it carries the boot policy
    assign mem_wren  = (state == S_WRITE);
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERR);
    assign core_hold = (state == S_IDLE) ? (BOOT_HOLD != 0) : (state != S_DONE);

endmodule

// File: tb/tb_imem_uart_loader.sv
module tb_imem_uart_loader;

    localparam int         CLK_DIV = 8;
    localparam logic [7:0] HDR     = 8'h55;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        rx    = 1'b1;
    logic [7:0]  mem_addr;
    logic [31:0] mem_din;
    logic        mem_wren, core_hold, done, error;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    imem_uart_loader #(
        .CLK_DIV   (CLK_DIV),
        .ADDR_WIDTH(8),
        .HEADER    (HDR),
        .BOOT_HOLD (1)
    ) dut (
        .clock    (clock),
        .clear    (clear),
        .rx       (rx),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_wren (mem_wren),
        .core_hold(core_hold),
        .done     (done),
        .error    (error)
    );

    // Strobe monitor: records every write and flags strobes wider than one cycle
    typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
    wr_t  obs_q[$];
    logic prev_wren = 1'b0;

    always @(posedge clock) begin
        wr_t w;
        #1;
        if (mem_wren) begin
            w.a = mem_addr;
            w.d = mem_din;
            obs_q.push_back(w);
            checks++;
            if (prev_wren) begin
                errors++;
                $display("FAIL strobe_width: mem_wren high 2 consecutive cycles, required 1");
            end
        end
        prev_wren = mem_wren;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        logic [9:0] frame;
        frame = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (CLK_DIV) @(negedge clock);
        end
        rx = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    task automatic check_byte(input string name, input bit wr, input logic [7:0] a,
                              input logic [31:0] d, input bit dn, input bit er, input bit hd);
        if (wr) begin
            chk({name, "_nwr"}, 32'(obs_q.size()), 32'd1);
            if (obs_q.size() > 0) begin
                chk({name, "_addr"}, 32'(obs_q[0].a), 32'(a));
                chk({name, "_din"}, obs_q[0].d, d);
            end
            chk({name, "_addr_hold"}, 32'(mem_addr), 32'(a));
            chk({name, "_din_hold"}, mem_din, d);
        end else begin
            chk({name, "_nwr"}, 32'(obs_q.size()), 32'd0);
        end
        obs_q.delete();
        chk({name, "_done"}, 32'(done), 32'(dn));
        chk({name, "_error"}, 32'(error), 32'(er));
        chk({name, "_hold"}, 32'(core_hold), 32'(hd));
    endtask

    task automatic do_reset(input string name);
        clear = 1'b0;
        #2;
        chk({name, "_addr"}, 32'(mem_addr), 32'd0);
        chk({name, "_din"}, mem_din, 32'd0);
        chk({name, "_wren"}, 32'(mem_wren), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_error"}, 32'(error), 32'd0);
        chk({name, "_hold"}, 32'(core_hold), 32'd1);
        repeat (3) @(negedge clock);
        rx = 1'b1;
        repeat (2) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        obs_q.delete();
    endtask

    // Byte-level reference model of the frame protocol
    int         m_phase;   // 0 waiting for header, 1 expecting length, 2 in data
    bit         m_done, m_err, m_hold;
    int         m_left, m_idx;
    logic [7:0] m_word[$];

    task automatic model_reset();
        m_phase = 0; m_done = 0; m_err = 0; m_hold = 1;
        m_left = 0; m_idx = 0; m_word.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ok, output bit wr,
                              output logic [7:0] a, output logic [31:0] d);
        wr = 0; a = '0; d = '0;
        if (m_phase == 0) begin
            if (ok && b == HDR) begin
                m_phase = 1; m_hold = 1; m_done = 0; m_err = 0;
            end
        end else if (m_phase == 1) begin
            if (!ok || b == 0 || b > 64) begin
                m_phase = 0; m_err = 1; m_hold = 1;
            end else begin
                m_left = int'(b); m_idx = 0; m_word.delete(); m_phase = 2;
            end
        end else begin
            if (!ok) begin
                m_phase = 0; m_err = 1; m_hold = 1;
            end else begin
                m_word.push_back(b);
                if (m_word.size() == 4) begin
                    wr = 1;
                    a  = 8'(m_idx * 4);
                    d  = {m_word[3], m_word[2], m_word[1], m_word[0]};
                    m_idx++; m_left--;
                    m_word.delete();
                    if (m_left == 0) begin
                        m_phase = 0; m_done = 1; m_hold = 0;
                    end
                end
            end
        end
    endtask

    typedef struct {
        logic [7:0]  b;  bit ok;
        bit wr; logic [7:0] a; logic [31:0] d;
        bit dn; bit er; bit hd;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] b, input bit ok, input bit wr,
                                input logic [7:0] a, input logic [31:0] d,
                                input bit dn, input bit er, input bit hd);
        vec_t v;
        v.b = b; v.ok = ok; v.wr = wr; v.a = a; v.d = d; v.dn = dn; v.er = er; v.hd = hd;
        return v;
    endfunction

    typedef struct { logic [7:0] b; bit ok; } rbyte_t;

    initial begin
        vec_t       tbl[$];
        rbyte_t     seq[$];
        rbyte_t     rb;
        bit         ewr;
        logic [7:0] ea;
        logic [31:0] ed, word;
        logic [7:0] db;
        int         n, kind, pos;

        // Normal load
        tbl.push_back(mk(8'h55, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'h02, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'h93, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'h00, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'hA0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'h00, 1, 1, 8'h00, 32'h00A00093, 0, 0, 1));
        tbl.push_back(mk(8'h13, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'h01, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'h40, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'h01, 1, 1, 8'h04, 32'h01400113, 1, 0, 0));
        // Header filter (leading junk ignored in DONE)
        tbl.push_back(mk(8'h12, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(8'h34, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(8'h55, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'h01, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'h23, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'h20, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'h10, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'h00, 1, 1, 8'h00, 32'h00102023, 1, 0, 0));
        // Framing error on 3rd data byte, then retry
        tbl.push_back(mk(8'h55, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'h01, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'hAA, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'hBB, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'hCC, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(8'h55, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'h01, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'h11, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'h22, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'h33, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'h44, 1, 1, 8'h00, 32'h44332211, 1, 0, 0));
        // Length checks
        tbl.push_back(mk(8'h55, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'h00, 1, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(8'h12, 1, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(8'h55, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8'h41, 1, 0, 0, 0, 0, 1, 1));

        // Reset state, then idle line produces nothing
        repeat (3) @(negedge clock);
        do_reset("reset");
        repeat (100) @(negedge clock);
        check_byte("idle100", 0, 0, 0, 0, 0, 1);

        foreach (tbl[i]) begin
            send_byte(tbl[i].b, tbl[i].ok);
            check_byte($sformatf("vec%0d", i), tbl[i].wr, tbl[i].a, tbl[i].d,
                       tbl[i].dn, tbl[i].er, tbl[i].hd);
        end

        // Maximum length N=64: 256 bytes, last word at 0xFC
        send_byte(8'h55, 1);
        check_byte("n64_hdr", 0, 0, 0, 0, 0, 1);
        send_byte(8'h40, 1);
        check_byte("n64_len", 0, 0, 0, 0, 0, 1);
        word = '0;
        for (int j = 0; j < 256; j++) begin
            db = 8'(j * 7 + 3);
            word[8 * (j % 4) +: 8] = db;
            send_byte(db, 1);
            if (j % 4 == 3)
                check_byte($sformatf("n64_w%0d", j / 4), 1, 8'(j - 3), word, (j == 255), 0, (j != 255));
            else
                check_byte($sformatf("n64_b%0d", j), 0, 0, 0, 0, 0, 1);
        end
        chk("n64_last_addr", 32'(mem_addr), 32'h000000FC);

        // Short low glitch while expecting the length byte must not become a byte
        send_byte(8'h55, 1);
        check_byte("gl_hdr", 0, 0, 0, 0, 0, 1);
        rx = 1'b0;
        repeat (2) @(negedge clock);
        rx = 1'b1;
        repeat (100) @(negedge clock);
        check_byte("gl_after", 0, 0, 0, 0, 0, 1);
        send_byte(8'h01, 1);
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        send_byte(8'h03, 1);
        obs_q.delete();
        send_byte(8'h04, 1);
        check_byte("gl_load", 1, 8'h00, 32'h04030201, 1, 0, 0);

        // Reset after 2 of 4 data bytes: nothing written, next frame starts at 0
        send_byte(8'h55, 1);
        send_byte(8'h01, 1);
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        do_reset("rst_mid");
        repeat (100) @(negedge clock);
        check_byte("rst_mid_idle", 0, 0, 0, 0, 0, 1);
        send_byte(8'h55, 1);
        send_byte(8'h01, 1);
        send_byte(8'hA1, 1);
        send_byte(8'hB2, 1);
        send_byte(8'hC3, 1);
        check_byte("rst_mid_part", 0, 0, 0, 0, 0, 1);
        send_byte(8'hD4, 1);
        check_byte("rst_mid_load", 1, 8'h00, 32'hD4C3B2A1, 1, 0, 0);

        // Reset in the middle of a byte on the line
        rx = 1'b0;
        repeat (20) @(negedge clock);
        do_reset("rst_byte");
        repeat (100) @(negedge clock);
        check_byte("rst_byte_idle", 0, 0, 0, 0, 0, 1);

        // Randomized frames against the reference model
        model_reset();
        for (int f = 0; f < 10; f++) begin
            seq.delete();
            kind = $urandom_range(0, 3);
            n    = $urandom_range(1, 3);
            if (kind == 0) begin
                rb.b = 8'($urandom_range(0, 255)); rb.ok = 1; seq.push_back(rb);
            end
            rb.ok = 1;
            rb.b = HDR; seq.push_back(rb);
            if (kind == 2) begin
                rb.b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(65, 255));
                seq.push_back(rb);
                for (int k = 0; k < 2; k++) begin
                    rb.b = 8'($urandom_range(0, 255)); seq.push_back(rb);
                end
            end else begin
                rb.b = 8'(n); seq.push_back(rb);
                pos = $urandom_range(0, 4 * n - 1);
                for (int k = 0; k < 4 * n; k++) begin
                    rb.b  = 8'($urandom_range(0, 255));
                    rb.ok = !(kind == 1 && k == pos);
                    seq.push_back(rb);
                end
            end
            foreach (seq[k]) begin
                model_byte(seq[k].b, seq[k].ok, ewr, ea, ed);
                send_byte(seq[k].b, seq[k].ok);
                check_byte($sformatf("rnd%0d_%0d", f, k), ewr, ea, ed, m_done, m_err, m_hold);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
